calc_alu_arbiter: RTL and testbench

Shares one calculator ALU between two requesters: for example, the keypad-driven calculator FSM and a test/replay port. Round-robin arbitration and valid/ready handshakes on both request and response sides. Sequences single-cycle ADD/SUB/MUL and an 8-step iterative DIV. Sits between the calculator control FSMs and the arithmetic datapath; only one operation is in flight at a time.

---
 rtl/calc_pkg.sv | 15 +
 rtl/calc_div8.sv | 66 ++++++
 rtl/calc_alu_arbiter.sv | 135 +++++++++++++
 tb/tb_calc_alu_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: op codes, width defaults and arbiter state type shared by the calculator ALU arbiter.
package calc_pkg;
   localparam int CALC_OP_W   = 3;
   localparam int CALC_DATA_W = 8;
   localparam int OP_ADD = 1;
   localparam int OP_SUB = 2;
   localparam int OP_MUL = 3;
   localparam int OP_DIV = 4;
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_DIV,
      ST_RESP
   } arb_state_t;
endpackage

// File: rtl/calc_div8.sv
// calc_div8: restoring unsigned divider, one quotient bit per cycle MSB first, done pulses after the last step.
module calc_div8
   import calc_pkg::*;
#(
   parameter int DATA_W = CALC_DATA_W
) (
   input  logic              clk,
   input  logic              clear_n,
   input  logic              start,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder
);
   localparam int CNT_W = $clog2(DATA_W + 1);
   logic [DATA_W-1:0] rem_q, rem_d, quo_q, quo_d, div_q, div_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              busy_q, busy_d, done_q, done_d;
   logic [DATA_W:0]   shifted, diff;
   always_comb begin
      shifted = {rem_q, quo_q[DATA_W-1]};
      diff    = shifted - {1'b0, div_q};
      rem_d   = rem_q;
      quo_d   = quo_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q && cnt_q != CNT_W'(1);
      done_d  = busy_q && cnt_q == CNT_W'(1);
      if (start) begin
         rem_d  = '0;
         quo_d  = a;
         div_d  = b;
         cnt_d  = CNT_W'(DATA_W);
         busy_d = 1'b1;
         done_d = 1'b0;
      end else if (busy_q) begin
         // a borrow out of the trial subtraction means this quotient bit is 0 and the remainder is restored
         rem_d = diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
         quo_d = {quo_q[DATA_W-2:0], ~diff[DATA_W]};
         cnt_d = cnt_q - CNT_W'(1);
      end
   end
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         rem_q  <= '0;
         quo_q  <= '0;
         div_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         div_q  <= div_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end
   assign busy      = busy_q;
   assign done      = done_q;
   assign quotient  = quo_q;
   assign remainder = rem_q;
endmodule

// File: rtl/calc_alu_arbiter.sv
// calc_alu_arbiter: round-robin sharing of one calculator ALU between two valid/ready requesters.
// Define CALC_ARB_DIV_EN to add the iterative divider; otherwise DIV reports an error like any unsupported op.
module calc_alu_arbiter
   import calc_pkg::*;
#(
   parameter int OP_W   = CALC_OP_W,
   parameter int DATA_W = CALC_DATA_W
) (
   input  logic                clk,
   input  logic                clear_n,
   input  logic [1:0]          req_valid,
   output logic [1:0]          req_ready,
   input  logic [OP_W-1:0]     req0_op,
   input  logic [OP_W-1:0]     req1_op,
   input  logic [DATA_W-1:0]   req0_a,
   input  logic [DATA_W-1:0]   req1_a,
   input  logic [DATA_W-1:0]   req0_b,
   input  logic [DATA_W-1:0]   req1_b,
   output logic [1:0]          rsp_valid,
   input  logic [1:0]          rsp_ready,
   output logic [2*DATA_W-1:0] rsp_result,
   output logic                rsp_err,
   output logic                busy,
   output logic                grant_id
);
   localparam int RW = 2 * DATA_W;
`ifdef CALC_ARB_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif
   arb_state_t        state_q, state_d;
   logic              last_grant_q, last_grant_d, grant_id_q, grant_id_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
   logic [RW-1:0]     result_q, result_d;
   logic              err_q, err_d;
   logic              grant, accept, sel_div, exec_err;
   logic [OP_W-1:0]   sel_op;
   logic [DATA_W-1:0] sel_a, sel_b;
   logic [RW-1:0]     a_x, b_x, exec_res;
`ifdef CALC_ARB_DIV_EN
   logic              div_start, div_done, div_busy;
   logic [DATA_W-1:0] div_quo;
   calc_div8 #(.DATA_W(DATA_W)) u_div (
      .clk       (clk),
      .clear_n   (clear_n),
      .start     (div_start),
      .a         (sel_a),
      .b         (sel_b),
      .busy      (div_busy),
      .done      (div_done),
      .quotient  (div_quo),
      .remainder ()
   );
   assign div_start = accept && sel_div;
`endif
   always_comb begin
      // tie goes to whoever was not served last
      grant     = &req_valid ? ~last_grant_q : req_valid[1];
      req_ready = (state_q == ST_IDLE && clear_n) ? req_valid & (2'b01 << grant) : 2'b00;
      accept    = |(req_valid & req_ready);
      sel_op    = grant ? req1_op : req0_op;
      sel_a     = grant ? req1_a : req0_a;
      sel_b     = grant ? req1_b : req0_b;
      sel_div   = sel_op == OP_W'(OP_DIV) && sel_b != '0;
      a_x       = {{DATA_W{1'b0}}, a_q};
      b_x       = {{DATA_W{1'b0}}, b_q};
      exec_res  = op_q == OP_W'(OP_ADD) ? a_x + b_x :
                  op_q == OP_W'(OP_SUB) ? a_x - b_x :
                  op_q == OP_W'(OP_MUL) ? a_x * b_x : '0;
      exec_err  = op_q != OP_W'(OP_ADD) && op_q != OP_W'(OP_SUB) && op_q != OP_W'(OP_MUL);
   end
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_id_d   = grant_id_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      result_d     = result_q;
      err_d        = err_q;
      case (state_q)
         ST_IDLE: if (accept) begin
            op_d         = sel_op;
            a_d          = sel_a;
            b_d          = sel_b;
            grant_id_d   = grant;
            last_grant_d = grant;
            // divide by zero takes the single-cycle error path instead of iterating
            state_d      = (DIV_EN && sel_div) ? ST_DIV : ST_EXEC;
         end
         ST_EXEC: begin
            result_d = exec_res;
            err_d    = exec_err;
            state_d  = ST_RESP;
         end
`ifdef CALC_ARB_DIV_EN
         ST_DIV: if (div_done) begin
            result_d = {{DATA_W{1'b0}}, div_quo};
            err_d    = 1'b0;
            state_d  = ST_RESP;
         end
`endif
         ST_RESP: if (rsp_ready[grant_id_q]) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         grant_id_q   <= 1'b0;
         op_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         result_q     <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_id_q   <= grant_id_d;
         op_q         <= op_d;
         a_q          <= a_d;
         b_q          <= b_d;
         result_q     <= result_d;
         err_q        <= err_d;
      end
   end
   assign rsp_valid  = (state_q == ST_RESP) ? (2'b01 << grant_id_q) : 2'b00;
   assign rsp_result = result_q;
   assign rsp_err    = err_q;
   assign busy       = state_q != ST_IDLE;
   assign grant_id   = grant_id_q;
endmodule

// File: tb/tb_calc_alu_arbiter.sv
// tb_calc_alu_arbiter: directed scoreboard bench for calc_alu_arbiter (DIV expectations follow CALC_ARB_DIV_EN).
module tb_calc_alu_arbiter;
   logic        clk = 1'b0;
   logic        clear_n;
   logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
   logic [2:0]  req0_op, req1_op;
   logic [7:0]  req0_a, req1_a, req0_b, req1_b;
   logic [15:0] rsp_result;
   logic        rsp_err, busy, grant_id;
   int          n_assert = 0;
   int          n_fail = 0;
`ifdef CALC_ARB_DIV_EN
   localparam int DIV_LAT = 9;
`else
   localparam int DIV_LAT = 1;
`endif
   typedef struct {
      int          id;
      logic [15:0] res;
      logic        err;
   } exp_t;
   exp_t sb[$];

   calc_alu_arbiter dut (
      .clk        (clk),
      .clear_n    (clear_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req0_op    (req0_op),
      .req1_op    (req1_op),
      .req0_a     (req0_a),
      .req1_a     (req1_a),
      .req0_b     (req0_b),
      .req1_b     (req1_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_err    (rsp_err),
      .busy       (busy),
      .grant_id   (grant_id)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end, expected $finish");
      $fatal(1, "timeout");
   end

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input int id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] res, input logic err);
      exp_t e;
      e.id = id; e.res = res; e.err = err;
      sb.push_back(e);
      if (id == 0) begin req0_op = op; req0_a = a; req0_b = b; end
      else begin req1_op = op; req1_a = a; req1_b = b; end
      req_valid[id] = 1'b1;
   endtask

   task automatic collect(input int lat_exp, input int hold);
      exp_t e;
      int   n;
      logic [15:0] held;
      e = sb.pop_front();
      #1;
      n = 0;
      while (!(req_valid[e.id] && req_ready[e.id]) && n < 20) begin tick; n++; end
      chk("accept_in_time", n < 20, 1);
      tick;
      req_valid[e.id] = 1'b0;
      chk("grant_id", grant_id, e.id);
      n = 0;
      while (rsp_valid == 2'b00 && n < 30) begin
         chk("busy_no_ready", {busy, req_ready}, 3'b100);
         tick;
         n++;
      end
      chk("latency", n, lat_exp);
      chk("rsp_valid_route", rsp_valid, e.id == 1 ? 2'b10 : 2'b01);
      chk("rsp_result", rsp_result, e.res);
      chk("rsp_err", rsp_err, e.err);
      held = rsp_result;
      for (int i = 0; i < hold; i++) begin
         tick;
         chk("hold_valid", rsp_valid, e.id == 1 ? 2'b10 : 2'b01);
         chk("hold_result", rsp_result, held);
      end
      rsp_ready = 2'b11;
      tick;
      chk("idle_after_hs", {busy, rsp_valid}, 3'b000);
   endtask

   initial begin
      clear_n   = 1'b0;
      rsp_ready = 2'b11;
      req_valid = 2'b00;
      req0_op = '0; req1_op = '0; req0_a = '0; req1_a = '0; req0_b = '0; req1_b = '0;
      issue(0, 3'd3, 8'd9, 8'd9, 16'd81, 1'b0);
      issue(1, 3'd2, 8'd3, 8'd5, 16'hFFFE, 1'b0);
      tick;
      chk("rst_req_ready", req_ready, 2'b00);
      chk("rst_rsp_valid", rsp_valid, 2'b00);
      chk("rst_result", rsp_result, 16'h0);
      chk("rst_err", rsp_err, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_grant_id", grant_id, 1'b0);
      clear_n = 1'b1;
      collect(1, 0);
      collect(1, 0);
      issue(0, 3'd1, 8'd7, 8'd9, 16'd16, 1'b0);
      collect(1, 0);
      issue(1, 3'd4, 8'd200, 8'd7, DIV_LAT == 9 ? 16'd28 : 16'd0, DIV_LAT != 9);
      issue(0, 3'd1, 8'd255, 8'd255, 16'h01FE, 1'b0);
      collect(DIV_LAT, 0);
      collect(1, 0);
      issue(0, 3'd4, 8'd5, 8'd0, 16'd0, 1'b1);
      collect(1, 0);
      issue(1, 3'd6, 8'd3, 8'd4, 16'd0, 1'b1);
      collect(1, 0);
      issue(0, 3'd4, 8'd8, 8'd2, DIV_LAT == 9 ? 16'd4 : 16'd0, DIV_LAT != 9);
      collect(DIV_LAT, 0);
      rsp_ready = 2'b10;
      issue(0, 3'd3, 8'd255, 8'd255, 16'hFE01, 1'b0);
      collect(1, 5);
      rsp_ready = 2'b00;
      req0_op = 3'd4; req0_a = 8'd200; req0_b = 8'd7;
      req_valid = 2'b01;
      #1;
      chk("abort_accept_ready", req_ready, 2'b01);
      tick;
      req_valid = 2'b00;
      tick;
      tick;
      tick;
      chk("abort_busy_before", busy, 1'b1);
      clear_n = 1'b0;
      #1;
      chk("abort_req_ready", req_ready, 2'b00);
      chk("abort_rsp_valid", rsp_valid, 2'b00);
      chk("abort_result", rsp_result, 16'h0);
      chk("abort_err", rsp_err, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_grant_id", grant_id, 1'b0);
      issue(0, 3'd1, 8'd10, 8'd20, 16'd30, 1'b0);
      issue(1, 3'd2, 8'd0, 8'd1, 16'hFFFF, 1'b0);
      #1;
      chk("abort_rst_ready", req_ready, 2'b00);
      tick;
      clear_n   = 1'b1;
      rsp_ready = 2'b11;
      collect(1, 0);
      collect(1, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
